// File: rtl/resp_return.sv
// Response-return and request-steering stage for one interconnect master port.
// Steers decoded requests to a slave and returns responses strictly in request order.
module resp_return #(
  parameter int PORT_COUNT      = 2,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int SEL_WIDTH       = $clog2(PORT_COUNT),
  parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [SEL_WIDTH-1:0]  req_sel_i,
  input  logic                  req_illegal_i,
  output logic [PORT_COUNT-1:0] slv_req_valid_o,
  input  logic [PORT_COUNT-1:0] slv_req_ready_i,
  input  logic [PORT_COUNT-1:0] slv_rsp_valid_i,
  output logic [PORT_COUNT-1:0] slv_rsp_ready_o,
  input  logic [DATA_WIDTH-1:0] slv_rsp_data_i [0:PORT_COUNT-1],
  input  logic [PORT_COUNT-1:0] slv_rsp_err_i,
  output logic                  mst_rsp_valid_o,
  input  logic                  mst_rsp_ready_i,
  output logic [DATA_WIDTH-1:0] mst_rsp_data_o,
  output logic                  mst_rsp_err_o,
  output logic [CNT_WIDTH-1:0]  outstanding_o
);

  localparam int PTR_WIDTH = $clog2(MAX_OUTSTANDING);

  typedef struct packed {
    logic                 ill;
    logic [SEL_WIDTH-1:0] sel;
  } entry_t;

  entry_t               queue_q [MAX_OUTSTANDING];
  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic   full;
  logic   empty;
  logic   eff_ill;
  logic   sel_ready;
  logic   push;
  logic   pop;
  entry_t head;

  assign full    = (count_q == CNT_WIDTH'(MAX_OUTSTANDING));
  assign empty   = (count_q == '0);
  assign eff_ill = req_illegal_i | (int'(req_sel_i) >= PORT_COUNT);
  assign head    = queue_q[rd_ptr_q];

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    slv_req_valid_o = '0;
    sel_ready       = 1'b0;
    for (int p = 0; p < PORT_COUNT; p++) begin
      if (req_sel_i == SEL_WIDTH'(p)) begin
        slv_req_valid_o[p] = req_valid_i & ~eff_ill & ~full & ~rst_i;
        sel_ready          = slv_req_ready_i[p];
      end
    end
  end

  assign req_ready_o = ~rst_i & ~full & (eff_ill | sel_ready);
  assign push        = req_valid_i & req_ready_o;

  // Only the head entry's port may hand a response over; all other ports are held off.
  always_comb begin
    mst_rsp_valid_o = 1'b0;
    mst_rsp_data_o  = '0;
    mst_rsp_err_o   = 1'b0;
    slv_rsp_ready_o = '0;
    if (!empty) begin
      if (head.ill) begin
        mst_rsp_valid_o = 1'b1;
        mst_rsp_err_o   = 1'b1;
      end else begin
        for (int p = 0; p < PORT_COUNT; p++) begin
          if (head.sel == SEL_WIDTH'(p)) begin
            mst_rsp_valid_o    = slv_rsp_valid_i[p];
            mst_rsp_data_o     = slv_rsp_data_i[p];
            mst_rsp_err_o      = slv_rsp_err_i[p];
            slv_rsp_ready_o[p] = mst_rsp_ready_i;
          end
        end
      end
    end
  end

  assign pop = mst_rsp_valid_o & mst_rsp_ready_i;

  // NOTE: the entry storage is not reset; count and pointers decide which slots are live,
  // so stale contents are never observed.
  always_ff @(posedge clk_i) begin
    if (push) queue_q[wr_ptr_q] <= {eff_ill, req_sel_i};
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign outstanding_o = count_q;

endmodule

// File: tb/tb_resp_return.sv
// Scoreboard bench for resp_return: directed stimulus pushes expected master responses,
// an independent negedge monitor pops and compares them.
module tb_resp_return;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [0:0]  req_sel_i = '0;
  logic        req_illegal_i = 1'b0;
  logic [1:0]  slv_req_valid_o;
  logic [1:0]  slv_req_ready_i = '0;
  logic [1:0]  slv_rsp_valid_i = '0;
  logic [1:0]  slv_rsp_ready_o;
  logic [31:0] slv_rsp_data_i [0:1];
  logic [1:0]  slv_rsp_err_i = '0;
  logic        mst_rsp_valid_o;
  logic        mst_rsp_ready_i = 1'b0;
  logic [31:0] mst_rsp_data_o;
  logic        mst_rsp_err_o;
  logic [2:0]  outstanding_o;

  // Three-port instance exercises out-of-range selects.
  logic        r3_req_valid = 1'b0;
  logic        r3_req_ready;
  logic [1:0]  r3_req_sel = '0;
  logic        r3_req_ill = 1'b0;
  logic [2:0]  r3_slv_req_valid;
  logic [2:0]  r3_slv_req_ready = '0;
  logic [2:0]  r3_slv_rsp_valid = '0;
  logic [2:0]  r3_slv_rsp_ready;
  logic [31:0] r3_slv_rsp_data [0:2];
  logic [2:0]  r3_slv_rsp_err = '0;
  logic        r3_mst_rsp_valid;
  logic        r3_mst_rsp_ready = 1'b0;
  logic [31:0] r3_mst_rsp_data;
  logic        r3_mst_rsp_err;
  logic [2:0]  r3_outstanding;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  resp_return #(.PORT_COUNT(2), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_sel_i(req_sel_i), .req_illegal_i(req_illegal_i),
    .slv_req_valid_o(slv_req_valid_o), .slv_req_ready_i(slv_req_ready_i),
    .slv_rsp_valid_i(slv_rsp_valid_i), .slv_rsp_ready_o(slv_rsp_ready_o),
    .slv_rsp_data_i(slv_rsp_data_i), .slv_rsp_err_i(slv_rsp_err_i),
    .mst_rsp_valid_o(mst_rsp_valid_o), .mst_rsp_ready_i(mst_rsp_ready_i),
    .mst_rsp_data_o(mst_rsp_data_o), .mst_rsp_err_o(mst_rsp_err_o),
    .outstanding_o(outstanding_o)
  );

  resp_return #(.PORT_COUNT(3), .DATA_WIDTH(32), .MAX_OUTSTANDING(4)) u_dut3 (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(r3_req_valid), .req_ready_o(r3_req_ready),
    .req_sel_i(r3_req_sel), .req_illegal_i(r3_req_ill),
    .slv_req_valid_o(r3_slv_req_valid), .slv_req_ready_i(r3_slv_req_ready),
    .slv_rsp_valid_i(r3_slv_rsp_valid), .slv_rsp_ready_o(r3_slv_rsp_ready),
    .slv_rsp_data_i(r3_slv_rsp_data), .slv_rsp_err_i(r3_slv_rsp_err),
    .mst_rsp_valid_o(r3_mst_rsp_valid), .mst_rsp_ready_i(r3_mst_rsp_ready),
    .mst_rsp_data_o(r3_mst_rsp_data), .mst_rsp_err_o(r3_mst_rsp_err),
    .outstanding_o(r3_outstanding)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic expect_rsp(input logic [31:0] data, input logic err);
    exp_t e;
    e.data = data;
    e.err  = err;
    sb.push_back(e);
  endtask

  // Monitor: pops the scoreboard on every master handshake and checks held responses stay put.
  initial begin
    logic        held = 1'b0;
    logic [31:0] held_data = '0;
    logic        held_err = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("hold_valid", 64'(mst_rsp_valid_o), 64'd1);
          check("hold_data", 64'(mst_rsp_data_o), 64'(held_data));
          check("hold_err", 64'(mst_rsp_err_o), 64'(held_err));
        end
        if (mst_rsp_valid_o && mst_rsp_ready_i) begin
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_rsp: got data 0x%0h with nothing expected at %0t",
                     mst_rsp_data_o, $time);
          end else begin
            e = sb.pop_front();
            check("rsp_data", 64'(mst_rsp_data_o), 64'(e.data));
            check("rsp_err", 64'(mst_rsp_err_o), 64'(e.err));
          end
        end
        held      = mst_rsp_valid_o && !mst_rsp_ready_i;
        held_data = mst_rsp_data_o;
        held_err  = mst_rsp_err_o;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int issued;
    int cyc;
    int served [2];
    int iss_port [2];

    slv_rsp_data_i[0] = '0;
    slv_rsp_data_i[1] = '0;
    for (int p = 0; p < 3; p++) r3_slv_rsp_data[p] = '0;

    // Reset state, with a request presented to show reset gates the handshake.
    req_valid_i = 1'b1;
    req_sel_i = 1'b1;
    slv_req_ready_i = 2'b11;
    #2;
    check("rst_outstanding", 64'(outstanding_o), 64'd0);
    check("rst_req_ready", 64'(req_ready_o), 64'd0);
    check("rst_slv_req_valid", 64'(slv_req_valid_o), 64'd0);
    check("rst_mst_valid", 64'(mst_rsp_valid_o), 64'd0);
    check("rst_slv_rsp_ready", 64'(slv_rsp_ready_o), 64'd0);
    tick();
    tick();

    // Single read on port 1; slave answers early, must wait until the entry is at the head.
    rst_i = 1'b0;
    mst_rsp_ready_i = 1'b1;
    slv_rsp_valid_i = 2'b10;
    slv_rsp_data_i[1] = 32'hDEADBEEF;
    #1;
    check("rd_slv_req_valid", 64'(slv_req_valid_o), 64'h2);
    check("rd_req_ready", 64'(req_ready_o), 64'd1);
    check("rd_early_rsp_ready", 64'(slv_rsp_ready_o), 64'd0);
    check("rd_out0", 64'(outstanding_o), 64'd0);
    expect_rsp(32'hDEADBEEF, 1'b0);
    tick();
    req_valid_i = 1'b0;
    #1;
    check("rd_slv_req_idle", 64'(slv_req_valid_o), 64'd0);
    check("rd_out1", 64'(outstanding_o), 64'd1);
    check("rd_rsp_ready", 64'(slv_rsp_ready_o), 64'h2);
    tick();
    slv_rsp_valid_i = '0;
    #1;
    check("rd_out_back0", 64'(outstanding_o), 64'd0);

    // Illegal request: no slave valid, accepted without slave ready, error returned next cycle.
    req_valid_i = 1'b1;
    req_illegal_i = 1'b1;
    req_sel_i = 1'b0;
    slv_req_ready_i = 2'b00;
    slv_rsp_valid_i = 2'b11;
    #1;
    check("ill_slv_req_valid", 64'(slv_req_valid_o), 64'd0);
    check("ill_req_ready", 64'(req_ready_o), 64'd1);
    expect_rsp(32'h0, 1'b1);
    tick();
    req_valid_i = 1'b0;
    req_illegal_i = 1'b0;
    #1;
    check("ill_mst_valid", 64'(mst_rsp_valid_o), 64'd1);
    check("ill_slv_rsp_ready", 64'(slv_rsp_ready_o), 64'd0);
    tick();
    slv_rsp_valid_i = '0;
    slv_req_ready_i = 2'b11;
    #1;
    check("ill_out0", 64'(outstanding_o), 64'd0);

    // Ordering: port 0 then port 1; port 1 answers first but is held off.
    req_valid_i = 1'b1;
    req_sel_i = 1'b0;
    expect_rsp(32'h22, 1'b0);
    tick();
    req_sel_i = 1'b1;
    slv_rsp_valid_i = 2'b10;
    slv_rsp_data_i[1] = 32'h11;
    #1;
    check("ord_hold1_a", 64'(slv_rsp_ready_o), 64'h1);
    expect_rsp(32'h11, 1'b0);
    tick();
    req_valid_i = 1'b0;
    #1;
    check("ord_hold1_b", 64'(slv_rsp_ready_o), 64'h1);
    check("ord_no_valid", 64'(mst_rsp_valid_o), 64'd0);
    tick();
    slv_rsp_valid_i = 2'b11;
    slv_rsp_data_i[0] = 32'h22;
    #1;
    check("ord_port0_ready", 64'(slv_rsp_ready_o), 64'h1);
    tick();
    slv_rsp_valid_i = 2'b10;
    #1;
    check("ord_port1_ready", 64'(slv_rsp_ready_o), 64'h2);
    tick();
    slv_rsp_valid_i = '0;
    #1;
    check("ord_out0", 64'(outstanding_o), 64'd0);

    // Full: four accepted, fifth blocked including the first pop cycle.
    req_valid_i = 1'b1;
    req_sel_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("full_accept", 64'(req_ready_o), 64'd1);
      expect_rsp(32'h100 + 32'(i), 1'b0);
      tick();
    end
    #1;
    check("full_out4", 64'(outstanding_o), 64'd4);
    check("full_block", 64'(req_ready_o), 64'd0);
    tick();
    slv_rsp_valid_i = 2'b01;
    slv_rsp_data_i[0] = 32'h100;
    #1;
    check("full_no_bypass", 64'(req_ready_o), 64'd0);
    tick();
    slv_rsp_data_i[0] = 32'h101;
    #1;
    check("full_accept5", 64'(req_ready_o), 64'd1);
    check("full_out3", 64'(outstanding_o), 64'd3);
    expect_rsp(32'h104, 1'b0);
    tick();
    req_valid_i = 1'b0;
    for (int k = 2; k < 5; k++) begin
      slv_rsp_data_i[0] = 32'h100 + 32'(k);
      tick();
    end
    slv_rsp_valid_i = '0;
    #1;
    check("full_out0", 64'(outstanding_o), 64'd0);

    // Backpressure and wrap: 10 alternating transactions, master ready toggles every cycle.
    issued = 0;
    cyc = 0;
    served = '{0, 0};
    iss_port = '{0, 0};
    while ((issued < 10 || sb.size() != 0) && cyc < 200) begin
      mst_rsp_ready_i = cyc[0];
      req_valid_i = (issued < 10);
      req_sel_i = issued[0];
      slv_rsp_valid_i = 2'b11;
      for (int p = 0; p < 2; p++)
        slv_rsp_data_i[p] = 32'hA000_0000 | (32'(p) << 8) | 32'(served[p]);
      #1;
      if (req_valid_i && req_ready_o) begin
        expect_rsp(32'hA000_0000 | (32'(req_sel_i) << 8) | 32'(iss_port[req_sel_i]), 1'b0);
        iss_port[req_sel_i]++;
        issued++;
      end
      for (int p = 0; p < 2; p++)
        if (slv_rsp_ready_o[p]) served[p]++;
      tick();
      cyc++;
    end
    req_valid_i = 1'b0;
    slv_rsp_valid_i = '0;
    mst_rsp_ready_i = 1'b1;
    #1;
    check("bp_issued", 64'(issued), 64'd10);
    check("bp_drained", 64'(sb.size()), 64'd0);
    check("bp_out0", 64'(outstanding_o), 64'd0);

    // Three-port instance: sel=3 is out of range and behaves as illegal; sel=2 steers to bit 2.
    r3_req_valid = 1'b1;
    r3_req_sel = 2'd3;
    r3_slv_req_ready = 3'b111;
    r3_mst_rsp_ready = 1'b1;
    #1;
    check("p3_oob_slv_valid", 64'(r3_slv_req_valid), 64'd0);
    check("p3_oob_ready", 64'(r3_req_ready), 64'd1);
    tick();
    r3_req_valid = 1'b0;
    #1;
    check("p3_err_valid", 64'(r3_mst_rsp_valid), 64'd1);
    check("p3_err_flag", 64'(r3_mst_rsp_err), 64'd1);
    check("p3_err_data", 64'(r3_mst_rsp_data), 64'd0);
    tick();
    #1;
    check("p3_out0", 64'(r3_outstanding), 64'd0);
    r3_req_valid = 1'b1;
    r3_req_sel = 2'd2;
    #1;
    check("p3_sel2_valid", 64'(r3_slv_req_valid), 64'h4);
    tick();
    r3_req_valid = 1'b0;

    // Reset mid-flight: three pending, one response held, async reset clears everything.
    mst_rsp_ready_i = 1'b0;
    req_valid_i = 1'b1;
    slv_req_ready_i = 2'b11;
    for (int i = 0; i < 3; i++) begin
      req_sel_i = 1'(i);
      tick();
    end
    req_valid_i = 1'b0;
    slv_rsp_valid_i = 2'b01;
    slv_rsp_data_i[0] = 32'h77;
    #1;
    check("mid_out3", 64'(outstanding_o), 64'd3);
    check("mid_held_valid", 64'(mst_rsp_valid_o), 64'd1);
    #1;
    rst_i = 1'b1;
    req_valid_i = 1'b1;
    req_sel_i = 1'b1;
    #1;
    check("mid_rst_out", 64'(outstanding_o), 64'd0);
    check("mid_rst_mst_valid", 64'(mst_rsp_valid_o), 64'd0);
    check("mid_rst_req_ready", 64'(req_ready_o), 64'd0);
    check("mid_rst_slv_req", 64'(slv_req_valid_o), 64'd0);
    check("mid_rst_slv_rsp_rdy", 64'(slv_rsp_ready_o), 64'd0);
    tick();
    tick();
    rst_i = 1'b0;
    slv_rsp_valid_i = '0;
    mst_rsp_ready_i = 1'b1;
    #1;
    check("post_req_ready", 64'(req_ready_o), 64'd1);
    expect_rsp(32'h5A5A_5A5A, 1'b1);
    tick();
    req_valid_i = 1'b0;
    slv_rsp_valid_i = 2'b10;
    slv_rsp_data_i[1] = 32'h5A5A_5A5A;
    slv_rsp_err_i = 2'b10;
    tick();
    slv_rsp_valid_i = '0;
    slv_rsp_err_i = '0;
    #1;
    check("post_out0", 64'(outstanding_o), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
